lcd_text_sequencer: RTL and testbench

LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

---
 rtl/lcd_pkg.sv | 15 +
 rtl/lcd_char_buffer.sv | 20 ++
 rtl/lcd_text_sequencer.sv | 82 ++++++++
 tb/tb_lcd_text_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: sequencer states, DDRAM address commands and the {RS, RW, data} instruction layout.
package lcd_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR1, ST_CHAR, ST_ADDR2, ST_WAIT} lcd_state_t;
    localparam int RS_BIT = 9;
    localparam int RW_BIT = 8;
    localparam logic [9:0] CMD_DDRAM_LINE1 = 10'h080;
    localparam logic [9:0] CMD_DDRAM_LINE2 = 10'h0C0;
    function automatic logic [9:0] char_cmd(input logic [7:0] c);
        logic [9:0] w;
        w = {2'b00, c};
        w[RS_BIT] = 1'b1;
        w[RW_BIT] = 1'b0;
        return w;
    endfunction
endpackage

// File: rtl/lcd_char_buffer.sv
// lcd_char_buffer: 32x8 character store, one synchronous write port and one asynchronous read port.
module lcd_char_buffer #(
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);
    logic [7:0] mem [32];
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            for (int i = 0; i < 32; i++) mem[i] <= BLANK_CHAR;
        else if (wr_en)
            mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer: streams the 2x16 character buffer to the LCD nibble transmitter,
// one instruction per request, then idles REFRESH_CYCLES cycles before the next frame.
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int         REFRESH_CYCLES = 1_000_000,
    parameter logic [7:0] BLANK_CHAR     = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       init_done,
    input  logic       instr_fsm_done,
    output logic       instr_fsm_enable,
    output logic [9:0] instruction,
    output logic       frame_done
);
    localparam int CW = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
    lcd_state_t state, state_d;
    logic [4:0] idx, idx_d;
    logic [CW-1:0] cnt, cnt_d;
    logic en_d, fd_d;
    logic [9:0] instr_d;
    logic [7:0] rd_data;
    lcd_char_buffer #(.BLANK_CHAR(BLANK_CHAR)) u_buf (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(idx), .rd_data(rd_data)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= ST_IDLE;
            idx <= '0;
            cnt <= '0;
            instr_fsm_enable <= 1'b0;
            instruction <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= state_d;
            idx <= idx_d;
            cnt <= cnt_d;
            instr_fsm_enable <= en_d;
            instruction <= instr_d;
            frame_done <= fd_d;
        end
    // A request state with enable low is the mandatory gap cycle: load the instruction now.
    always_comb begin
        state_d = state;
        idx_d = idx;
        cnt_d = cnt;
        en_d = instr_fsm_enable;
        instr_d = instruction;
        fd_d = 1'b0;
        if (!init_done) begin
            state_d = ST_IDLE;
            idx_d = '0;
            cnt_d = '0;
            en_d = 1'b0;
        end else if (state == ST_IDLE || (state == ST_WAIT && cnt == CNT_LAST)) begin
            state_d = ST_ADDR1;
            idx_d = '0;
            cnt_d = '0;
            en_d = 1'b1;
            instr_d = CMD_DDRAM_LINE1;
        end else if (state == ST_WAIT) begin
            cnt_d = cnt + 1'b1;
        end else if (!instr_fsm_enable) begin
            en_d = 1'b1;
            instr_d = state == ST_ADDR1 ? CMD_DDRAM_LINE1 :
                      state == ST_ADDR2 ? CMD_DDRAM_LINE2 : char_cmd(rd_data);
        end else if (instr_fsm_done) begin
            en_d = 1'b0;
            state_d = (state == ST_ADDR1 || state == ST_ADDR2) ? ST_CHAR :
                      idx == 5'd15 ? ST_ADDR2 : idx == 5'd31 ? ST_WAIT : ST_CHAR;
            idx_d = state == ST_ADDR1 ? 5'd0 : state == ST_ADDR2 ? 5'd16 :
                    idx == 5'd15 ? idx : idx + 5'd1;
            fd_d = state == ST_CHAR && idx == 5'd31;
        end
    end
endmodule

// File: tb/tb_lcd_text_sequencer.sv
// tb_lcd_text_sequencer: randomized frame checks against a buffer model and a done-after-3-cycles transmitter.
module tb_lcd_text_sequencer;
    localparam int R = 10;
    logic clk = 1'b0, reset = 1'b0, wr_en = 1'b0, init_done = 1'b0, instr_fsm_done = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic instr_fsm_enable, frame_done;
    logic [9:0] instruction;
    logic [7:0] ref_buf [32];
    int passed = 0, total = 0;

    lcd_text_sequencer #(.REFRESH_CYCLES(R), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_done(init_done), .instr_fsm_done(instr_fsm_done),
        .instr_fsm_enable(instr_fsm_enable), .instruction(instruction), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [4:0] idx_of(input int k);
        return k <= 16 ? 5'(k - 1) : 5'(k - 2);
    endfunction

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        ref_buf[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Acts as the transmitter for one frame; expected sequence comes from the buffer model.
    // gap: expected cycle of the first enable rise; stop_k: return right after that item rises.
    // hit_mode 1 writes the latched entry, 2 writes the entry in the cycle it is loaded.
    task automatic run_frame(input string tag, input int gap, input bit spur, input int stop_k,
                             input int hit_k, input int hit_mode, input logic [7:0] hd);
        logic [9:0] exp_q[$];
        logic [9:0] held = '0;
        int k = 0, cd = 0, hold = 0, cyc = 0, fd_cnt = 0, fd_cyc = -1, last_done = -100, bad = 0;
        bit prev_en = 1'b0;
        exp_q.push_back(10'h080);
        for (int i = 0; i < 32; i++) begin
            if (i == 16) exp_q.push_back(10'h0C0);
            exp_q.push_back({2'b10, ref_buf[i]});
        end
        while (cyc < 2000 && !(k == 34 && fd_cnt > 0)) begin
            @(negedge clk);
            cyc++;
            wr_en = 1'b0;
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    instr_fsm_done = 1'b0;
                    if (hit_mode == 2 && hit_k == k) begin
                        wr_en = 1'b1; wr_addr = idx_of(k); wr_data = hd; ref_buf[idx_of(k)] = hd;
                    end
                end
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    instr_fsm_done = 1'b1;
                    hold = spur ? 2 : 1;
                    last_done = cyc;
                end
            end
            if (last_done == cyc - 1 && instr_fsm_enable) bad++;
            if (instr_fsm_enable && !prev_en) begin
                if (k == 0 && gap >= 0) begin
                    total++;
                    if (cyc !== gap) $display("FAIL %s gap: got %0d cycles want %0d", tag, cyc, gap);
                    else passed++;
                end
                total++;
                if (k >= exp_q.size()) $display("FAIL %s extra request: got %h want none", tag, instruction);
                else if (instruction !== exp_q[k]) $display("FAIL %s item %0d: got %h want %h", tag, k, instruction, exp_q[k]);
                else passed++;
                held = instruction;
                cd = 3;
                if (hit_mode == 1 && hit_k == k) begin
                    wr_en = 1'b1; wr_addr = idx_of(k); wr_data = hd; ref_buf[idx_of(k)] = hd;
                end
                k++;
                if (k - 1 == stop_k) begin
                    instr_fsm_done = 1'b0;
                    return;
                end
            end else if (instr_fsm_enable && instruction !== held) bad++;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (spur && k == 0 && cyc == 2) begin
                instr_fsm_done = 1'b1;
                hold = 1;
            end
            prev_en = instr_fsm_enable;
        end
        instr_fsm_done = 1'b0;
        wr_en = 1'b0;
        total++;
        if (k !== 34) $display("FAIL %s count: got %0d requests want 34", tag, k);
        else passed++;
        total++;
        if (fd_cnt !== 1) $display("FAIL %s frame_done pulses: got %0d want 1", tag, fd_cnt);
        else passed++;
        total++;
        if (fd_cyc !== last_done + 1) $display("FAIL %s frame_done timing: got cycle %0d want %0d", tag, fd_cyc, last_done + 1);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL %s handshake: got %0d violations want 0", tag, bad);
        else passed++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
        repeat (2) @(negedge clk);
        total++;
        if (instr_fsm_enable !== 1'b0) $display("FAIL reset enable: got %b want 0", instr_fsm_enable);
        else passed++;
        total++;
        if (instruction !== 10'h000) $display("FAIL reset instruction: got %h want 000", instruction);
        else passed++;
        total++;
        if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b want 0", frame_done);
        else passed++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (instr_fsm_enable !== 1'b0) $display("FAIL idle enable: got %b want 0", instr_fsm_enable);
        else passed++;
    endtask

    task automatic test_blank_frame();
        init_done = 1'b1;
        run_frame("blank", 1, 1'b0, -1, -1, 0, 8'h00);
    endtask

    task automatic test_write_latched();
        run_frame("latched", R, 1'b1, -1, 6, 1, 8'h41);
        run_frame("latched_next", R, 1'b0, -1, -1, 0, 8'h00);
    endtask

    task automatic test_init_drop();
        int bad = 0;
        logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        run_frame("drop", R, 1'b0, 12, -1, 0, 8'h00);
        init_done = 1'b0;
        @(negedge clk);
        total++;
        if (instr_fsm_enable !== 1'b0) $display("FAIL drop enable: got %b want 0", instr_fsm_enable);
        else passed++;
        for (int i = 0; i < 5; i++) host_write(5'(i), hello[i]);
        host_write(5'd5, 8'h20);
        for (int i = 0; i < 8; i++) begin
            instr_fsm_done = i[0];
            @(negedge clk);
            if (instr_fsm_enable) bad++;
        end
        instr_fsm_done = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL drop idle: got %0d enabled cycles want 0", bad);
        else passed++;
        init_done = 1'b1;
        run_frame("hello", 1, 1'b0, -1, -1, 0, 8'h00);
    endtask

    task automatic test_load_collision();
        int k = $urandom_range(1, 33);
        if (k == 17) k = 18;
        run_frame("collide", R, 1'b0, -1, k, 2, 8'($urandom));
        run_frame("collide_next", R, 1'b0, -1, -1, 0, 8'h00);
    endtask

    task automatic test_random_content();
        for (int n = 0; n < 2; n++) begin
            init_done = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 32; i++) host_write(5'(i), 8'($urandom));
            init_done = 1'b1;
            run_frame("random", 1, 1'b0, -1, -1, 0, 8'h00);
        end
    endtask

    task automatic test_reset_mid();
        run_frame("pre_reset", R, 1'b0, 22, -1, 0, 8'h00);
        reset = 1'b0;
        #1;
        total++;
        if (instr_fsm_enable !== 1'b0) $display("FAIL mid reset enable: got %b want 0", instr_fsm_enable);
        else passed++;
        total++;
        if (instruction !== 10'h000) $display("FAIL mid reset instruction: got %h want 000", instruction);
        else passed++;
        for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        run_frame("post_reset", 1, 1'b0, -1, -1, 0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_blank_frame();
        test_write_latched();
        test_init_drop();
        test_load_collision();
        test_random_content();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
